silife_max7219_scan: RTL and testbench

SILIFE_MAX7219_SCAN -- requirements
Module: silife_max7219_scan

---
 rtl/silife_pkg.sv | 47 ++++
 rtl/silife_spi_tx.sv | 106 ++++++++++
 rtl/silife_max7219_scan.sv | 142 ++++++++++++++
 tb/tb_silife_max7219_scan.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/silife_pkg.sv
// Shared definitions for the MAX7219 grid scanner: register addresses, FSM states, word builders.
// Latency: none (constants and pure functions only).
// Backpressure: not applicable.
package silife_pkg;

   // MAX7219 register addresses (upper byte of each 16-bit command word)
   localparam logic [3:0] ADDR_NOOP         = 4'h0;
   localparam logic [3:0] ADDR_DIGIT0       = 4'h1;
   localparam logic [3:0] ADDR_DECODE       = 4'h9;
   localparam logic [3:0] ADDR_INTENSITY    = 4'hA;
   localparam logic [3:0] ADDR_SCAN_LIMIT   = 4'hB;
   localparam logic [3:0] ADDR_SHUTDOWN     = 4'hC;
   localparam logic [3:0] ADDR_DISPLAY_TEST = 4'hF;

   // Index of the last word in the power-up init sequence
   localparam logic [2:0] INIT_LAST = 3'd4;

   typedef enum logic [2:0] {
      IDLE,
      INIT,
      LOAD,
      SHIFT,
      GAP,
      DONE
   } state_e;

   // Power-up sequence: display test off, leave shutdown, scan all 8 digits,
   // no BCD decode, then brightness.
   function automatic logic [15:0] init_word(input logic [2:0] idx, input logic [3:0] intensity);
      logic [15:0] w;
      w = {4'h0, ADDR_INTENSITY, 4'h0, intensity};
      case (idx)
         3'd0:    w = {4'h0, ADDR_DISPLAY_TEST, 8'h00};
         3'd1:    w = {4'h0, ADDR_SHUTDOWN, 8'h01};
         3'd2:    w = {4'h0, ADDR_SCAN_LIMIT, 8'h07};
         3'd3:    w = {4'h0, ADDR_DECODE, 8'h00};
         default: w = {4'h0, ADDR_INTENSITY, 4'h0, intensity};
      endcase
      return w;
   endfunction

   // Grid row r goes to digit register r+1 (1..8); the 4-bit add cannot wrap.
   function automatic logic [15:0] row_word(input logic [2:0] row, input logic [7:0] cells);
      return {4'h0, ADDR_DIGIT0 + {1'b0, row}, cells};
   endfunction

endpackage

// File: rtl/silife_spi_tx.sv
// Serialises one 16-bit word MSB first (SCK low then high, CLK_DIV cycles each), then holds CS_N high for a 2*CLK_DIV gap.
// Latency: load to done pulse is 34*CLK_DIV cycles; done is asserted in the last gap cycle.
// Backpressure: none; a load always (re)starts a word, so the caller only loads when idle or on done.
module silife_spi_tx
   import silife_pkg::*;
#(
   parameter int CLK_DIV = 1
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        load,
   input  logic [15:0] word,
   output logic        spi_sck,
   output logic        spi_mosi,
   output logic        spi_cs_n,
   output logic        shift_end,
   output logic        done
);

   localparam logic [8:0] DIV_LAST = 9'(CLK_DIV - 1);
   localparam logic [8:0] GAP_LAST = 9'(2 * CLK_DIV - 1);

   logic [15:0] shreg_q, shreg_d;
   logic [8:0]  div_q, div_d;
   logic [3:0]  bit_q, bit_d;
   logic        sck_q, sck_d;
   logic        cs_n_q, cs_n_d;
   logic        active_q, active_d;
   logic        gap_q, gap_d;

   // MOSI is the shifter MSB, so it only moves when the shifter moves (at SCK falling).
   assign spi_sck   = sck_q;
   assign spi_mosi  = shreg_q[15];
   assign spi_cs_n  = cs_n_q;
   assign shift_end = active_q & ~gap_q & sck_q & (div_q == DIV_LAST) & (bit_q == 4'd15);
   assign done      = active_q & gap_q & (div_q == GAP_LAST);

   // Serial link registers; reset drops the link to idle so no further SCK edges appear
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         shreg_q  <= '0;
         div_q    <= '0;
         bit_q    <= '0;
         sck_q    <= 1'b0;
         cs_n_q   <= 1'b1;
         active_q <= 1'b0;
         gap_q    <= 1'b0;
      end else begin
         shreg_q  <= shreg_d;
         div_q    <= div_d;
         bit_q    <= bit_d;
         sck_q    <= sck_d;
         cs_n_q   <= cs_n_d;
         active_q <= active_d;
         gap_q    <= gap_d;
      end
   end

   // Divider / bit counter sequencing for the shift phase and the CS_N gap
   always_comb begin
      shreg_d  = shreg_q;
      div_d    = div_q;
      bit_d    = bit_q;
      sck_d    = sck_q;
      cs_n_d   = cs_n_q;
      active_d = active_q;
      gap_d    = gap_q;
      if (load) begin
         shreg_d  = word;
         div_d    = '0;
         bit_d    = '0;
         sck_d    = 1'b0;
         cs_n_d   = 1'b0;
         active_d = 1'b1;
         gap_d    = 1'b0;
      end else if (active_q && !gap_q) begin
         if (div_q == DIV_LAST) begin
            div_d = '0;
            if (!sck_q) begin
               sck_d = 1'b1;
            end else if (bit_q == 4'd15) begin
               // Last high phase finished: raise CS_N to latch the word
               sck_d   = 1'b0;
               cs_n_d  = 1'b1;
               gap_d   = 1'b1;
               shreg_d = '0;
            end else begin
               sck_d   = 1'b0;
               bit_d   = bit_q + 4'd1;
               shreg_d = {shreg_q[14:0], 1'b0};
            end
         end else begin
            div_d = div_q + 9'd1;
         end
      end else if (active_q) begin
         if (div_q == GAP_LAST) begin
            div_d    = '0;
            active_d = 1'b0;
            gap_d    = 1'b0;
         end else begin
            div_d = div_q + 9'd1;
         end
      end
   end

endmodule

// File: rtl/silife_max7219_scan.sv
// Streams the 8x8 grid to a MAX7219 as 8 digit words per start; optional init words when SILIFE_MAX7219_INIT_EN is defined.
// Latency: 1+34*CLK_DIV cycles per row word, 8 words per frame (+5*34*CLK_DIV for init on the first frame after reset).
// Backpressure: start is accepted only in IDLE; starts while busy are dropped, not queued.
module silife_max7219_scan
   import silife_pkg::*;
#(
   parameter int         CLK_DIV   = 1,
   parameter logic [3:0] INTENSITY = 4'h8
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       start,
   output logic       busy,
   output logic       frame_done,
   output logic [2:0] row_select,
   input  logic [7:0] cells,
   output logic       spi_sck,
   output logic       spi_mosi,
   output logic       spi_cs_n
);

   state_e      state_q, state_d;
   logic [2:0]  row_q, row_d;
   logic        tx_load;
   logic [15:0] tx_word;
   logic        tx_shift_end;
   logic        tx_done;
`ifdef SILIFE_MAX7219_INIT_EN
   logic        init_pend_q, init_pend_d;
   logic [2:0]  init_idx_q, init_idx_d;
`endif

   assign busy       = (state_q != IDLE) && (state_q != DONE);
   assign frame_done = (state_q == DONE);
   assign row_select = row_q;

   // FSM state, row counter and (optionally) init sequencer registers
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= IDLE;
         row_q       <= '0;
`ifdef SILIFE_MAX7219_INIT_EN
         init_pend_q <= 1'b1;
         init_idx_q  <= '0;
`endif
      end else begin
         state_q     <= state_d;
         row_q       <= row_d;
`ifdef SILIFE_MAX7219_INIT_EN
         init_pend_q <= init_pend_d;
         init_idx_q  <= init_idx_d;
`endif
      end
   end

   // Next-state logic and word selection for the transmitter
   always_comb begin
      state_d     = state_q;
      row_d       = row_q;
      tx_load     = 1'b0;
      tx_word     = row_word(row_q, cells);
`ifdef SILIFE_MAX7219_INIT_EN
      init_pend_d = init_pend_q;
      init_idx_d  = init_idx_q;
`endif
      case (state_q)
         IDLE: begin
            if (start) begin
               row_d = '0;
`ifdef SILIFE_MAX7219_INIT_EN
               if (init_pend_q) begin
                  // Init words skip LOAD: the first one is loaded on the accepting edge
                  state_d     = INIT;
                  tx_load     = 1'b1;
                  tx_word     = init_word(3'd0, INTENSITY);
                  init_idx_d  = 3'd0;
                  init_pend_d = 1'b0;
               end else begin
                  state_d = LOAD;
               end
`else
               state_d = LOAD;
`endif
            end
         end
`ifdef SILIFE_MAX7219_INIT_EN
         INIT: begin
            if (tx_done) begin
               if (init_idx_q == INIT_LAST) begin
                  state_d = LOAD;
               end else begin
                  // Back-to-back: next init word starts the cycle after the gap ends
                  tx_load    = 1'b1;
                  tx_word    = init_word(init_idx_q + 3'd1, INTENSITY);
                  init_idx_d = init_idx_q + 3'd1;
               end
            end
         end
`endif
         LOAD: begin
            tx_load = 1'b1;
            state_d = SHIFT;
         end
         SHIFT: begin
            if (tx_shift_end) begin
               state_d = GAP;
            end
         end
         GAP: begin
            if (tx_done) begin
               if (row_q == 3'd7) begin
                  state_d = DONE;
               end else begin
                  row_d   = row_q + 3'd1;
                  state_d = LOAD;
               end
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   silife_spi_tx #(
      .CLK_DIV (CLK_DIV)
   ) u_spi_tx (
      .clk       (clk),
      .reset_n   (reset_n),
      .load      (tx_load),
      .word      (tx_word),
      .spi_sck   (spi_sck),
      .spi_mosi  (spi_mosi),
      .spi_cs_n  (spi_cs_n),
      .shift_end (tx_shift_end),
      .done      (tx_done)
   );

endmodule

// File: tb/tb_silife_max7219_scan.sv
// Directed bench for silife_max7219_scan: one instance at CLK_DIV=1, one at CLK_DIV=3.
// Expected SPI words are queued at each start and popped as CS_N rises on the link.
// Init-word expectations follow SILIFE_MAX7219_INIT_EN as defined for the build.
module tb_silife_max7219_scan;

   localparam logic [3:0] INTEN = 4'h3;

   logic       clk;
   logic       reset_n;
   logic       start0, start3;
   logic       busy0, busy3, fd0, fd3;
   logic [2:0] rs0, rs3;
   logic [7:0] cells0, cells3;
   logic       sck0, sck3, mosi0, mosi3, cs0, cs3;
   logic [7:0] grid0 [8];
   logic [7:0] grid3 [8];

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   logic [15:0] exp0 [$];
   logic [15:0] exp3 [$];
   bit          armed [2];

   assign cells0 = grid0[rs0];
   assign cells3 = grid3[rs3];

   silife_max7219_scan #(.CLK_DIV(1), .INTENSITY(INTEN)) dut0 (
      .clk(clk), .reset_n(reset_n), .start(start0), .busy(busy0), .frame_done(fd0),
      .row_select(rs0), .cells(cells0), .spi_sck(sck0), .spi_mosi(mosi0), .spi_cs_n(cs0));

   silife_max7219_scan #(.CLK_DIV(3), .INTENSITY(INTEN)) dut3 (
      .clk(clk), .reset_n(reset_n), .start(start3), .busy(busy3), .frame_done(fd3),
      .row_select(rs3), .cells(cells3), .spi_sck(sck3), .spi_mosi(mosi3), .spi_cs_n(cs3));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input int obs, input int expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s observed=%0d (0x%0h) expected=%0d (0x%0h)", tag, obs, obs, expv, expv);
      end
   endtask

   // ---------------- link monitor (samples on falling clk edge) ----------------
   logic [1:0]  sck_p  = 2'b00;
   logic [1:0]  mosi_p = 2'b00;
   logic [1:0]  cs_p   = 2'b11;
   logic [15:0] sh     [2];
   int nbits [2], nlow [2], run [2], rises [2], windows [2], fdones [2], viol [2], last_fall [2];
   bit has_prev [2];

   initial begin
      for (int k = 0; k < 2; k++) begin
         nbits[k] = 0; nlow[k] = 0; run[k] = 0; rises[k] = 0; windows[k] = 0;
         fdones[k] = 0; viol[k] = 0; last_fall[k] = 0; has_prev[k] = 0; sh[k] = '0;
      end
   end

   always @(negedge clk) begin
      logic [1:0]  sck_v, mosi_v, cs_v, fd_v;
      logic [15:0] head, got;
      int d, per;
      cyc++;
      sck_v  = {sck3, sck0};
      mosi_v = {mosi3, mosi0};
      cs_v   = {cs3, cs0};
      fd_v   = {fd3, fd0};
      for (int k = 0; k < 2; k++) begin
         d = (k == 0) ? 1 : 3;
         if (sck_v[k] && !sck_p[k]) rises[k]++;
         if (!reset_n) begin
            nbits[k]    = 0;
            has_prev[k] = 0;
         end else begin
            if (fd_v[k]) begin
               fdones[k]++;
               has_prev[k] = 0;
            end
            if (cs_v[k] && sck_v[k]) viol[k]++;
            if (!cs_v[k] && cs_p[k]) begin
               nbits[k] = 0;
               nlow[k]  = 0;
               run[k]   = 0;
               if (k == 0) head = (exp0.size() > 0) ? exp0[0] : 16'hFFFF;
               else        head = (exp3.size() > 0) ? exp3[0] : 16'hFFFF;
               if (has_prev[k]) begin
                  per = (head[11:8] <= 4'd8) ? 1 + 34 * d : 34 * d;
                  chk($sformatf("word_period_div%0d", d), cyc - last_fall[k], per);
               end
               last_fall[k] = cyc;
               has_prev[k]  = 1;
            end
            if (!cs_v[k]) begin
               nlow[k]++;
               if (!cs_p[k] && sck_v[k] != sck_p[k]) begin
                  if (run[k] != d) viol[k]++;
                  run[k] = 1;
               end else begin
                  run[k]++;
               end
               if (sck_v[k] && !sck_p[k]) begin
                  if (mosi_v[k] != mosi_p[k]) viol[k]++;
                  sh[k] = {sh[k][14:0], mosi_v[k]};
                  nbits[k]++;
               end
               if (sck_v[k] && sck_p[k] && mosi_v[k] != mosi_p[k]) viol[k]++;
            end
            if (cs_v[k] && !cs_p[k]) begin
               if (run[k] != d) viol[k]++;
               windows[k]++;
               chk($sformatf("cs_low_len_div%0d", d), nlow[k], 32 * d);
               chk($sformatf("bits_per_word_div%0d", d), nbits[k], 16);
               got = sh[k];
               if (k == 0) head = (exp0.size() > 0) ? exp0.pop_front() : 16'hFFFF;
               else        head = (exp3.size() > 0) ? exp3.pop_front() : 16'hFFFF;
               chk($sformatf("spi_word_div%0d", d), int'(got), int'(head));
            end
         end
         sck_p[k]  = sck_v[k];
         mosi_p[k] = mosi_v[k];
         cs_p[k]   = cs_v[k];
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_start(input int k, input logic v);
      if (k == 0) start0 = v;
      else        start3 = v;
   endtask

   task automatic push_frame(input int k);
      logic [15:0] w;
      logic [15:0] init_tab [5];
      init_tab[0] = 16'h0F00; init_tab[1] = 16'h0C01; init_tab[2] = 16'h0B07;
      init_tab[3] = 16'h0900; init_tab[4] = {8'h0A, 4'h0, INTEN};
      if (armed[k]) begin
         for (int i = 0; i < 5; i++) begin
            if (k == 0) exp0.push_back(init_tab[i]);
            else        exp3.push_back(init_tab[i]);
         end
         armed[k] = 0;
      end
      for (int r = 0; r < 8; r++) begin
         w = {4'h0, 4'(r + 1), (k == 0) ? grid0[r] : grid3[r]};
         if (k == 0) exp0.push_back(w);
         else        exp3.push_back(w);
      end
   endtask

   task automatic run_frame(input int k, input int ra, input int rb);
      int d, n, expn, w0, f0, nwin;
      logic fd;
      d    = (k == 0) ? 1 : 3;
      expn = 8 * (1 + 34 * d) + (armed[k] ? 170 * d : 0);
      nwin = armed[k] ? 13 : 8;
      w0   = windows[k];
      f0   = fdones[k];
      push_frame(k);
      set_start(k, 1'b1);
      tick();
      set_start(k, 1'b0);
      chk("busy_after_start", (k == 0) ? busy0 : busy3, 1);
      chk("row_sel_after_start", (k == 0) ? rs0 : rs3, 0);
      n  = 0;
      fd = 1'b0;
      while (!fd && n < 4000) begin
         tick();
         n++;
         set_start(k, (n == ra || n == rb));
         fd = (k == 0) ? fd0 : fd3;
      end
      set_start(k, 1'b0);
      chk("frame_done_cycle", n, expn);
      chk("busy_at_frame_done", (k == 0) ? busy0 : busy3, 0);
      tick();
      chk("frame_done_one_cycle", (k == 0) ? fd0 : fd3, 0);
      chk("row_sel_hold_idle", (k == 0) ? rs0 : rs3, 7);
      repeat (4) tick();
      chk("idle_after_frame", (k == 0) ? busy0 : busy3, 0);
      chk("cs_windows", windows[k] - w0, nwin);
      chk("frame_done_count", fdones[k] - f0, 1);
      chk("queue_drained", (k == 0) ? exp0.size() : exp3.size(), 0);
   endtask

   // ---------------- directed sequence ----------------
   initial begin
      int n, target, r0;
      bit init_en;
`ifdef SILIFE_MAX7219_INIT_EN
      init_en = 1;
`else
      init_en = 0;
`endif
      reset_n = 1'b0;
      start0  = 1'b0;
      start3  = 1'b0;
      for (int r = 0; r < 8; r++) begin
         grid0[r] = 8'h00;
         grid3[r] = 8'(8'h81 ^ (r * 8'h13));
      end
      grid0[4] = 8'h70;
      armed[0] = init_en;
      armed[1] = init_en;
      repeat (3) tick();

      // Reset state
      chk("rst_busy", busy0, 0);
      chk("rst_frame_done", fd0, 0);
      chk("rst_row_sel", rs0, 0);
      chk("rst_cs_n", cs0, 1);
      chk("rst_sck", sck0, 0);
      chk("rst_mosi", mosi0, 0);
      chk("rst_cs_n_div3", cs3, 1);
      reset_n = 1'b1;
      repeat (2) tick();

      // Frame A: row4=0x70 only, restart attempts at cycles 5 and 100 are dropped
      run_frame(0, 5, 100);

      // Frame B: different pattern; init never repeats
      for (int r = 0; r < 8; r++) grid0[r] = 8'(8'hA5 + r * 8'h11);
      run_frame(0, -1, -1);

      // Reset during bit 9 of row 3
      for (int r = 0; r < 8; r++) grid0[r] = 8'(8'h3C ^ r);
      push_frame(0);
      target = (armed[0] ? 170 : 0) + 3 * 35 + 1 + 2 * 9;
      start0 = 1'b1;
      tick();
      start0 = 1'b0;
      n = 0;
      while (n < target) begin
         tick();
         n++;
      end
      chk("mid_word_cs_low", cs0, 0);
      chk("mid_word_row", rs0, 3);
      reset_n = 1'b0;
      #1;
      chk("abort_cs_n", cs0, 1);
      chk("abort_sck", sck0, 0);
      chk("abort_busy", busy0, 0);
      chk("abort_row_sel", rs0, 0);
      chk("abort_words_left", exp0.size(), 5);
      exp0.delete();
      r0 = rises[0];
      repeat (3) tick();
      reset_n = 1'b1;
      armed[0] = init_en;
      armed[1] = init_en;
      repeat (30) tick();
      chk("no_sck_after_abort", rises[0] - r0, 0);
      chk("idle_after_abort", busy0, 0);

      // Frame C after reset (init sequence re-armed when enabled)
      for (int r = 0; r < 8; r++) grid0[r] = 8'(1 << r);
      run_frame(0, -1, -1);

      // CLK_DIV = 3 instance
      run_frame(1, -1, -1);

      chk("link_timing_div1", viol[0], 0);
      chk("link_timing_div3", viol[1], 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
